link_training_timer: RTL
========================

Name: link_training_timer

Overview:
Parametrised wait-interval timer for the DP link-training FSM. It times the Clock Recovery (CR) and Channel Equalization (EQ) wait windows before the source reads the sink's adjust-request DPCD registers. Compared with the fixed 100 kHz counter, it adds:
- a clock-rate parameter;
- a down-counter with a visible remaining count;
- abort, retrigger and a busy flag;
- single-cycle registered fire pulses.

Parameters:
CLK_PER_100US, 10, clk cycles per 100 us (10 at 100 kHz); must be >= 1.
CNT_W, 12, counter width; must satisfy 160*CLK_PER_100US < 2**CNT_W.

Ports:
clk  in  1  timer clock
rst_n  in  1  asynchronous active-low reset
cr_tmr_start  in  1  level; rising edge starts a CR wait
eq_tmr_start  in  1  level; rising edge starts an EQ wait
eq_rd_value  in  8  TRAINING_AUX_RD_INTERVAL; sampled only on eq_tmr_start rising edge
tmr_abort  in  1  synchronous abort; cancels any wait
cr_tmr_fire  out  1  one-cycle pulse: CR wait elapsed
eq_tmr_fire  out  1  one-cycle pulse: EQ wait elapsed
tmr_busy  out  1  high while a wait is in progress
tmr_remaining  out  CNT_W  edges left until fire; 0 when idle

Behaviour:
- Clock and reset:
  - Single clock domain; reset is asynchronous and active-low.
  - On reset: all outputs = 0, state = IDLE, edge-detect history = 0.
- Edge detect:
  - rise = start & ~start_prev; start_prev is registered each cycle.
  - A start held high gives exactly one rise.
- States: IDLE, CR_WAIT, EQ_WAIT.
- Load value L, computed in CNT_W bits:
  - CR: L = 1*CLK_PER_100US (100 us).
  - EQ, by eq_rd_value: 0x00 → 4*CLK_PER_100US (400 us); 0x01 → 40* (4 ms); 0x02 → 80* (8 ms); 0x03 → 120* (12 ms); 0x04 → 160* (16 ms); any other value → 160* (clamp to max).
- Timing, with the rise sampled at edge E0:
  - At E0: state → CR_WAIT or EQ_WAIT; tmr_busy → 1; tmr_remaining → L.
  - At each edge E0+k: tmr_remaining = L-k.
  - At E0+L: tmr_remaining = 0, tmr_busy → 0, state → IDLE, and the matching fire → 1.
  - At E0+L+1: the fire pulse falls back to 0.
  - Fire is registered and exactly one cycle wide.
- Latency: the fire pulse rises exactly L edges after the sampled start edge. Default CR latency = 10 cycles.
- Priority, evaluated every cycle from highest to lowest:
  1. tmr_abort
  2. eq rise
  3. cr rise
  4. countdown
- Abort:
  - Forces IDLE, tmr_busy = 0, tmr_remaining = 0, no fire.
  - A start rise in the same cycle is discarded; start_prev still updates.
- Simultaneous rises: cr and eq rising together start EQ_WAIT; the CR request is dropped.
- Retrigger: a rise while busy (either type) reloads L for the new type and changes state. The old wait never fires.
- Retrigger in the fire cycle: if a rise lands on the edge where the count would reach 0, the new load wins and the old wait does not fire.
- Fires are never asserted together; tmr_remaining never wraps below 0.
- Reset mid-operation: immediate return to reset values; no fire.

Optional Feature:
Macro: LT_TMR_EXT_INTERVAL_EN
- Defined: bit 7 of eq_rd_value (EXTENDED_RECEIVER_CAPABILITY_FIELD_PRESENT) is masked before decode; only bits [6:0] select the interval. Example: 0x81 → 4 ms.
- Undefined: the full 8-bit value is decoded. Example: 0x81 → default clamp, 16 ms.

Test Plan:
1. Reset, then pulse cr_tmr_start high at edge E0 → tmr_remaining = 10 at E0; cr_tmr_fire high only during the cycle after E0+10; eq_tmr_fire stays 0; tmr_busy falls at E0+10.
2. eq_tmr_start rise with eq_rd_value = 0x02 → eq_tmr_fire exactly 800 cycles later. With 0x00 → 40 cycles. With 0x09 → 1600 cycles.
3. EQ start with eq_rd_value = 0x04; assert tmr_abort at remaining = 700 → tmr_busy = 0, tmr_remaining = 0 next edge; no fire over the following 2000 cycles.
4. CR start, then EQ rise (eq_rd_value = 0x00) at remaining = 5 → no cr_tmr_fire; eq_tmr_fire 40 cycles after the EQ edge.
5. cr_tmr_start and eq_tmr_start rise on the same edge with eq_rd_value = 0x01 → EQ_WAIT, eq_tmr_fire after 400 cycles, no CR fire. Hold both starts high → no further fires.
6. eq_rd_value = 0x81 → fire after 400 cycles with LT_TMR_EXT_INTERVAL_EN defined; after 1600 cycles without it. Also assert rst_n low mid-wait → outputs 0 immediately, no fire after release.

Source files
------------

// File: rtl/link_training_timer_if.sv
// Signal bundle between the DP link-training FSM (master) and its wait-interval timer (slave).
interface link_training_timer_if #(
    parameter int CNT_W = 12
);
    logic             cr_tmr_start;
    logic             eq_tmr_start;
    logic [7:0]       eq_rd_value;
    logic             tmr_abort;
    logic             cr_tmr_fire;
    logic             eq_tmr_fire;
    logic             tmr_busy;
    logic [CNT_W-1:0] tmr_remaining;

    modport master (
        output cr_tmr_start, eq_tmr_start, eq_rd_value, tmr_abort,
        input  cr_tmr_fire, eq_tmr_fire, tmr_busy, tmr_remaining
    );

    modport slave (
        input  cr_tmr_start, eq_tmr_start, eq_rd_value, tmr_abort,
        output cr_tmr_fire, eq_tmr_fire, tmr_busy, tmr_remaining
    );
endinterface

// File: rtl/link_training_timer.sv
// CR/EQ wait-interval down-counter with abort, retrigger and one-cycle fire pulses.
// Optional: LT_TMR_EXT_INTERVAL_EN masks eq_rd_value[7] before interval decode.
module link_training_timer #(
    parameter int CLK_PER_100US = 10,
    parameter int CNT_W         = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    link_training_timer_if.slave  tmr
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CR_WAIT = 2'd1,
        EQ_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] L_CR  = CNT_W'(CLK_PER_100US);
    localparam logic [CNT_W-1:0] L_EQ0 = CNT_W'(4 * CLK_PER_100US);
    localparam logic [CNT_W-1:0] L_EQ1 = CNT_W'(40 * CLK_PER_100US);
    localparam logic [CNT_W-1:0] L_EQ2 = CNT_W'(80 * CLK_PER_100US);
    localparam logic [CNT_W-1:0] L_EQ3 = CNT_W'(120 * CLK_PER_100US);
    localparam logic [CNT_W-1:0] L_EQ4 = CNT_W'(160 * CLK_PER_100US);

    state_t           r_state;
    logic             r_cr_prev;
    logic             r_eq_prev;
    logic             r_cr_fire;
    logic             r_eq_fire;
    logic             r_busy;
    logic [CNT_W-1:0] r_remaining;

    logic             w_cr_rise;
    logic             w_eq_rise;

    // Unknown interval codes clamp to the longest (16 ms) wait.
    function automatic logic [CNT_W-1:0] eq_load(input logic [7:0] rd);
        logic [7:0] sel;
`ifdef LT_TMR_EXT_INTERVAL_EN
        sel = {1'b0, rd[6:0]};
`else
        sel = rd;
`endif
        case (sel)
            8'h00:   return L_EQ0;
            8'h01:   return L_EQ1;
            8'h02:   return L_EQ2;
            8'h03:   return L_EQ3;
            8'h04:   return L_EQ4;
            default: return L_EQ4;
        endcase
    endfunction

    assign w_cr_rise = tmr.cr_tmr_start & ~r_cr_prev;
    assign w_eq_rise = tmr.eq_tmr_start & ~r_eq_prev;

    // Start-edge history, state machine, countdown and fire pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cr_prev   <= 1'b0;
            r_eq_prev   <= 1'b0;
            r_cr_fire   <= 1'b0;
            r_eq_fire   <= 1'b0;
            r_busy      <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_cr_prev <= tmr.cr_tmr_start;
            r_eq_prev <= tmr.eq_tmr_start;
            r_cr_fire <= 1'b0;
            r_eq_fire <= 1'b0;
            if (tmr.tmr_abort) begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_remaining <= '0;
            end else if (w_eq_rise) begin
                r_state     <= EQ_WAIT;
                r_busy      <= 1'b1;
                r_remaining <= eq_load(tmr.eq_rd_value);
            end else if (w_cr_rise) begin
                r_state     <= CR_WAIT;
                r_busy      <= 1'b1;
                r_remaining <= L_CR;
            end else begin
                case (r_state)
                    CR_WAIT, EQ_WAIT: begin
                        // Compare against 1 so the count can never wrap below 0.
                        if (r_remaining <= CNT_W'(1)) begin
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_remaining <= '0;
                            r_cr_fire   <= (r_state == CR_WAIT);
                            r_eq_fire   <= (r_state == EQ_WAIT);
                        end else begin
                            r_remaining <= r_remaining - CNT_W'(1);
                        end
                    end
                    IDLE: begin
                        r_busy      <= 1'b0;
                        r_remaining <= '0;
                    end
                    default: begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_remaining <= '0;
                    end
                endcase
            end
        end
    end

    assign tmr.cr_tmr_fire   = r_cr_fire;
    assign tmr.eq_tmr_fire   = r_eq_fire;
    assign tmr.tmr_busy      = r_busy;
    assign tmr.tmr_remaining = r_remaining;
endmodule
